ascon_stream_io: RTL and testbench
==================================

// Module: ascon_stream_io
// PURPOSE
//  Host-side stream counterpart of the Ascon encryption core's data FIFOs. Turns a 32-bit valid/ready
//  input stream into 64-bit pushes into the AD FIFO, then the PT FIFO. Drains the CT FIFO and the
//  128-bit tag into a 32-bit valid/ready output stream. Sits between the subsystem bus bridge and the FIFOs.
// PARAMETERS
//  DataAddrWidth  7  width of ad_size_i/pt_size_i; block counts, unit is one 64-bit word
// PORTS
//  clk_i         in   1    clock
//  rst_n_i       in   1    reset, asynchronous, active-low
//  start_i       in   1    arm a transfer; sizes sampled on this cycle
//  ad_size_i     in   DAW  AD block count (0 allowed)
//  pt_size_i     in   DAW  PT/CT block count (0 allowed)
//  busy_o        out  1    transfer armed and not finished
//  done_o        out  1    1-cycle pulse: last tag beat accepted
//  s_valid_i/s_ready_o/s_data_i  in/out/in  1/1/32  input stream
//  m_valid_o/m_ready_i/m_data_o  out/in/out 1/1/32  output stream
//  m_last_o      out  1    asserted with the final tag beat
//  ad_push_o/ad_data_o/ad_full_i  out/out/in 1/64/1  AD FIFO write side
//  pt_push_o/pt_data_o/pt_full_i  out/out/in 1/64/1  PT FIFO write side
//  ct_pop_o/ct_data_i/ct_empty_i  out/in/in  1/64/1  CT FIFO read side, first-word-fall-through
//  tag_i         in   128  tag from core
//  tag_valid_i   in   1    tag valid; level or pulse
// BEHAVIOUR
//  Reset: all outputs 0, both FSMs idle, partial word and tag register cleared.
//  Reset mid-operation: transfer dropped; held half-word and counters lost.
//  start_i: accepted only when !busy_o; ignored while busy. Arms the input FSM and the output FSM together.
//  Input FSM: IN_IDLE -> IN_AD -> IN_PT -> IN_DONE.
//   - A zero-size phase is skipped in the start cycle.
//   - IN_DONE -> IN_IDLE when the output FSM finishes.
//   - Two beats form one word: first beat = bits [63:32], held in hi_q; second beat = [31:0].
//   - s_ready_o = phase in {IN_AD,IN_PT} && !(hi_held && target_full).
//   - Push is combinational on the second-beat handshake: *_push_o=1, *_data_o={hi_q,s_data_i}.
//   - Block counter increments per push. Last push of a phase advances the FSM in that same cycle.
//   - In IN_DONE/IN_IDLE, s_ready_o=0; surplus beats stall.
//  Output FSM: OUT_IDLE -> OUT_CT -> OUT_TAG -> OUT_IDLE.
//   - Skip OUT_CT if pt_size=0.
//   - OUT_CT: if the buffer is empty and !ct_empty_i, assert ct_pop_o for 1 cycle and load the 64-bit buffer.
//     m_valid_o rises the next cycle. Emit [63:32], then [31:0]. m_valid_o/m_data_o are stable until m_ready_i.
//     No pop while the buffer holds an unsent half.
//   - Tag capture: tag_i is captured on the first armed cycle with tag_valid_i=1, even during OUT_CT.
//     A later tag_valid_i is ignored until the next start.
//   - OUT_TAG: entered after the last CT low half is accepted. If the tag is not yet captured, wait.
//     Emit 4 beats, tag[127:96] first. m_last_o on the 4th beat.
//     done_o pulses the cycle after that beat's handshake; busy_o falls with it.
//  Simultaneous: input push and output pop in the same cycle are independent. m_ready_i may toggle freely.
//  Counters are DAW bits wide. Compare for equality with the sampled size; no wrap occurs.
// CONFIGURATION
//  ASCON_IO_ERR_EN defined:
//   - adds output err_o (1 bit), sticky, cleared by an accepted start_i.
//   - err_o sets on start_i while busy.
//   - err_o sets on s_valid_i held high in IN_DONE.
//   - err_o sets on tag_valid_i observed before the input FSM reaches IN_DONE.
//  Not defined: no err_o port; those events are silently ignored or stalled as above.
// STRUCTURE
//  ascon_pack additions:
//   - typedefs io_in_state_e {IN_IDLE,IN_AD,IN_PT,IN_DONE} and io_out_state_e {OUT_IDLE,OUT_CT,OUT_TAG}.
//   - localparams IoBeatWidth=32, TagBeats=4.
//  Sub-module ascon_word_serializer: 64-bit load, 2-beat valid/ready emitter with a 2-bit beat count.
//   Reused for CT words and, loaded twice, for the tag.
// TESTING
//  1. start, ad=2, pt=3; 10 beats, FIFOs never full
//     -> 2 ad_push then 3 pt_push; ad_data_o=64'h00000001_00000002 for beats 1,2.
//  2. ad=0, pt=0, tag_valid_i pulse with tag 128'h0123..cdef
//     -> no pushes, exactly 4 beats 32'h01234567.., m_last_o on beat 4, done_o next cycle.
//  3. pt=2, CT FIFO holds 64'hAAAA_BBBB_CCCC_DDDD and 64'h1111_2222_3333_4444; m_ready_i toggles 1/0
//     -> 8 beats in order AAAABBBB, CCCCDDDD, 11112222, 33334444, then tag; data is held while m_ready_i=0.
//  4. pt_full_i=1 while the high half is held
//     -> s_ready_o=0, no push; after pt_full_i drops, push occurs on the next handshake.
//  5. tag_valid_i arrives before the CT drain completes
//     -> tag beats follow the last CT beat with no gap; a second start mid-transfer changes nothing.
//     With ASCON_IO_ERR_EN, err_o=1.
//  6. rst_n_i low mid-IN_PT with the high half held
//     -> all outputs 0 immediately; next start with ad=1 pushes a fresh word and the stale half is not reused.

Source files
------------

// File: rtl/ascon_stream_io_pkg.sv
// ascon_stream_io_pkg: shared states and widths for the Ascon host stream adapter
package ascon_stream_io_pkg;
  typedef enum logic [1:0] {IN_IDLE, IN_AD, IN_PT, IN_DONE} io_in_state_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_CT, OUT_TAG} io_out_state_e;
  localparam int IoBeatWidth = 32;
  localparam int TagBeats = 4;
endpackage

// File: rtl/ascon_stream_io_word_serializer.sv
// ascon_word_serializer: loads a 64-bit word and emits it as two 32-bit valid/ready beats, high half first
module ascon_word_serializer
  import ascon_stream_io_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     load_i,
  input  logic [2*IoBeatWidth-1:0] data_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [IoBeatWidth-1:0]   data_o,
  output logic                     lo_o,
  output logic                     free_o
);
  logic [2*IoBeatWidth-1:0] buf_q;
  logic [1:0]               beat_q;
  assign valid_o = beat_q != 2'd0;
  assign lo_o    = beat_q == 2'd1;
  assign data_o  = beat_q == 2'd2 ? buf_q[2*IoBeatWidth-1:IoBeatWidth] : lo_o ? buf_q[IoBeatWidth-1:0] : '0;
  // A new word may be loaded while the final half is being accepted, giving gapless output.
  assign free_o  = beat_q == 2'd0 || (lo_o && ready_i);
  // Beat count: 2 = high half pending, 1 = low half pending, 0 = empty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q  <= '0;
      beat_q <= 2'd0;
    end else if (load_i) begin
      buf_q  <= data_i;
      beat_q <= 2'd2;
    end else if (valid_o && ready_i) begin
      beat_q <= beat_q - 2'd1;
    end
  end
endmodule

// File: rtl/ascon_stream_io.sv
// ascon_stream_io: 32-bit stream to AD/PT FIFO packer and CT/tag to 32-bit stream drainer (optional err_o via ASCON_IO_ERR_EN)
module ascon_stream_io
  import ascon_stream_io_pkg::*;
#(
  parameter int DataAddrWidth = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start_i,
  input  logic [DataAddrWidth-1:0] ad_size_i,
  input  logic [DataAddrWidth-1:0] pt_size_i,
  output logic                     busy_o,
  output logic                     done_o,
`ifdef ASCON_IO_ERR_EN
  output logic                     err_o,
`endif
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [IoBeatWidth-1:0]   s_data_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [IoBeatWidth-1:0]   m_data_o,
  output logic                     m_last_o,
  output logic                     ad_push_o,
  output logic [63:0]              ad_data_o,
  input  logic                     ad_full_i,
  output logic                     pt_push_o,
  output logic [63:0]              pt_data_o,
  input  logic                     pt_full_i,
  output logic                     ct_pop_o,
  input  logic [63:0]              ct_data_i,
  input  logic                     ct_empty_i,
  input  logic [127:0]             tag_i,
  input  logic                     tag_valid_i
);
  localparam int Daw = DataAddrWidth;
  localparam logic [1:0] TagHalves = 2'(TagBeats / 2);
  io_in_state_e   in_q;
  io_out_state_e  out_q;
  logic           busy_q, done_q, hi_held_q, tag_got_q;
  logic [IoBeatWidth-1:0] hi_q;
  logic [Daw-1:0] ad_size_q, pt_size_q, in_cnt_q, ct_cnt_q;
  logic [127:0]   tag_q;
  logic [1:0]     tag_part_q;
  logic start_acc, in_phase, tgt_full, s_hs, push, phase_last;
  logic ser_free, ser_lo, ser_hs, ct_pop, tag_zone, tag_load, last_hs;
  logic [63:0] ser_data;
  assign start_acc  = start_i && !busy_q;
  assign in_phase   = in_q == IN_AD || in_q == IN_PT;
  assign tgt_full   = in_q == IN_AD ? ad_full_i : pt_full_i;
  assign s_ready_o  = in_phase && !(hi_held_q && tgt_full);
  assign s_hs       = s_valid_i && s_ready_o;
  assign push       = s_hs && hi_held_q;
  assign ad_push_o  = push && in_q == IN_AD;
  assign pt_push_o  = push && in_q == IN_PT;
  assign ad_data_o  = ad_push_o ? {hi_q, s_data_i} : '0;
  assign pt_data_o  = pt_push_o ? {hi_q, s_data_i} : '0;
  assign phase_last = in_cnt_q + Daw'(1) == (in_q == IN_AD ? ad_size_q : pt_size_q);
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  // Input side: pair beats into words and step through the AD then PT phases.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      in_q      <= IN_IDLE;
      hi_q      <= '0;
      hi_held_q <= 1'b0;
      in_cnt_q  <= '0;
      ad_size_q <= '0;
      pt_size_q <= '0;
    end else if (start_acc) begin
      ad_size_q <= ad_size_i;
      pt_size_q <= pt_size_i;
      in_cnt_q  <= '0;
      hi_held_q <= 1'b0;
      in_q      <= ad_size_i != '0 ? IN_AD : pt_size_i != '0 ? IN_PT : IN_DONE;
    end else begin
      if (s_hs) begin
        hi_held_q <= !hi_held_q;
        if (!hi_held_q) hi_q <= s_data_i;
      end
      if (push) begin
        in_cnt_q <= phase_last ? '0 : in_cnt_q + Daw'(1);
        if (phase_last) in_q <= (in_q == IN_AD && pt_size_q != '0) ? IN_PT : IN_DONE;
      end
      if (last_hs) in_q <= IN_IDLE;
    end
  end
  assign ser_hs   = m_valid_o && m_ready_i;
  assign ct_pop   = out_q == OUT_CT && ser_free && !ct_empty_i && ct_cnt_q != pt_size_q;
  assign ct_pop_o = ct_pop;
  // The cycle the last CT low half is accepted already counts as tag territory so the tag follows without a gap.
  assign tag_zone = out_q == OUT_TAG || (out_q == OUT_CT && ct_cnt_q == pt_size_q && ser_hs && ser_lo);
  assign tag_load = tag_zone && ser_free && tag_got_q && tag_part_q != TagHalves;
  assign ser_data = ct_pop ? ct_data_i : tag_part_q == 2'd0 ? tag_q[127:64] : tag_q[63:0];
  assign last_hs  = out_q == OUT_TAG && tag_part_q == TagHalves && ser_hs && ser_lo;
  assign m_last_o = out_q == OUT_TAG && tag_part_q == TagHalves && ser_lo;
  ascon_word_serializer u_ser (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (ct_pop || tag_load),
    .data_i  (ser_data),
    .ready_i (m_ready_i),
    .valid_o (m_valid_o),
    .data_o  (m_data_o),
    .lo_o    (ser_lo),
    .free_o  (ser_free)
  );
  // Output side: drain CT words, then the captured tag, and signal completion.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q      <= OUT_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tag_q      <= '0;
      tag_got_q  <= 1'b0;
      tag_part_q <= 2'd0;
      ct_cnt_q   <= '0;
    end else begin
      done_q <= last_hs;
      if (start_acc) begin
        busy_q     <= 1'b1;
        out_q      <= pt_size_i != '0 ? OUT_CT : OUT_TAG;
        tag_got_q  <= 1'b0;
        tag_part_q <= 2'd0;
        ct_cnt_q   <= '0;
      end else begin
        if (busy_q && !tag_got_q && tag_valid_i) begin
          tag_q     <= tag_i;
          tag_got_q <= 1'b1;
        end
        if (ct_pop) ct_cnt_q <= ct_cnt_q + Daw'(1);
        if (tag_load) tag_part_q <= tag_part_q + 2'd1;
        if (tag_zone && out_q == OUT_CT) out_q <= OUT_TAG;
        if (last_hs) begin
          out_q  <= OUT_IDLE;
          busy_q <= 1'b0;
        end
      end
    end
  end
`ifdef ASCON_IO_ERR_EN
  logic err_q;
  assign err_o = err_q;
  // Sticky protocol-misuse flag, cleared by the next accepted start.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_q <= 1'b0;
    else err_q <= !start_acc && (err_q || (start_i && busy_q) || (s_valid_i && in_q == IN_DONE) ||
                                 (tag_valid_i && busy_q && in_q != IN_DONE));
  end
`endif
endmodule

// File: tb/tb_ascon_stream_io.sv
// tb_ascon_stream_io: directed table-driven bench for ascon_stream_io (optional err_o via ASCON_IO_ERR_EN)
module tb_ascon_stream_io;
  logic clk = 1'b0;
  logic rst_n_i = 1'b0;
  logic start_i = 1'b0;
  logic [6:0] ad_size_i = '0, pt_size_i = '0;
  logic busy_o, done_o, s_ready_o, m_valid_o, m_last_o, ad_push_o, pt_push_o, ct_pop_o;
  logic s_valid_i = 1'b0, m_ready_i = 1'b1, ad_full_i = 1'b0, pt_full_i = 1'b0, ct_empty_i = 1'b1, tag_valid_i = 1'b0;
  logic [31:0] s_data_i = '0, m_data_o;
  logic [63:0] ad_data_o, pt_data_o, ct_data_i = '0;
  logic [127:0] tag_i = 128'h0123456789abcdef_fedcba9876543210;
`ifdef ASCON_IO_ERR_EN
  logic err_o;
`endif

  ascon_stream_io dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .ad_size_i(ad_size_i), .pt_size_i(pt_size_i),
    .busy_o(busy_o), .done_o(done_o),
`ifdef ASCON_IO_ERR_EN
    .err_o(err_o),
`endif
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
    .ad_push_o(ad_push_o), .ad_data_o(ad_data_o), .ad_full_i(ad_full_i),
    .pt_push_o(pt_push_o), .pt_data_o(pt_data_o), .pt_full_i(pt_full_i),
    .ct_pop_o(ct_pop_o), .ct_data_i(ct_data_i), .ct_empty_i(ct_empty_i),
    .tag_i(tag_i), .tag_valid_i(tag_valid_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ad; int pt; bit tog; logic [63:0] ct0; logic [63:0] ct1; int n_ad; int n_pt; int n_beats;
  } vec_t;

  int ntests = 0, nfail = 0;
  int nad, npt, nbeats, ndone, exp_ad_left, src_left, cyc;
  logic [31:0] src_data = 32'd1, last_beat;
  logic [63:0] first_ad;
  logic half = 1'b0, tog = 1'b0, last_prev = 1'b0, hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic s_hs_n = 1'b0, m_hs_n = 1'b0, pop_n = 1'b0;
  logic [63:0] ctq[$];
  logic [32:0] expq[$];
  int beat_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: sample handshakes mid-cycle, check pushes, beats, hold and done timing.
  always @(negedge clk) begin
    s_hs_n = s_valid_i && s_ready_o;
    m_hs_n = m_valid_o && m_ready_i;
    pop_n  = ct_pop_o;
    if (rst_n_i) begin
      if (hold_pend) begin
        chk("hold_valid", m_valid_o, 1'b1);
        chk("hold_data", m_data_o, hold_data);
      end
      hold_pend = m_valid_o && !m_ready_i;
      hold_data = m_data_o;
      if (ad_push_o) begin
        if (nad == 0) first_ad = ad_data_o;
        nad++;
      end
      if (pt_push_o) npt++;
      if (s_hs_n) begin
        if (half) begin
          chk("push_sel", {ad_push_o, pt_push_o}, exp_ad_left > 0 ? 2'b10 : 2'b01);
          chk("push_data", ad_push_o ? ad_data_o : pt_data_o, {last_beat, s_data_i});
          if (exp_ad_left > 0) exp_ad_left--;
        end else chk("no_push_first_beat", {ad_push_o, pt_push_o}, 2'b00);
        last_beat = s_data_i;
        half = !half;
      end
      if (m_hs_n) begin
        nbeats++;
        beat_cyc.push_back(cyc);
        if (expq.size() == 0) chk("unexpected_beat", {m_last_o, m_data_o}, 33'h0);
        else chk("m_beat", {m_last_o, m_data_o}, expq.pop_front());
      end
      if (last_prev || done_o) chk("done_timing", done_o, last_prev);
      if (done_o) begin
        ndone++;
        chk("busy_falls_with_done", busy_o, 1'b0);
      end
      last_prev = m_hs_n && m_last_o;
    end
  end

  // Environment: input source, first-word-fall-through CT FIFO and m_ready pattern.
  always @(posedge clk) begin
    #1;
    if (s_hs_n && src_left > 0) begin
      src_left--;
      src_data++;
    end
    s_valid_i = src_left > 0;
    s_data_i = src_data;
    if (pop_n && ctq.size() > 0) void'(ctq.pop_front());
    ct_empty_i = ctq.size() == 0;
    ct_data_i = ctq.size() > 0 ? ctq[0] : 64'h0;
    m_ready_i = tog ? !m_ready_i : 1'b1;
    cyc++;
  end

  task automatic cyc_step();
    @(posedge clk);
    #2;
  endtask

  task automatic load_expect(input int pt, input logic [63:0] ct0, input logic [63:0] ct1);
    for (int j = 0; j < pt; j++) begin
      logic [63:0] w;
      w = j == 0 ? ct0 : j == 1 ? ct1 : ct0 + 64'(j);
      ctq.push_back(w);
      expq.push_back({1'b0, w[63:32]});
      expq.push_back({1'b0, w[31:0]});
    end
    expq.push_back({1'b0, tag_i[127:96]});
    expq.push_back({1'b0, tag_i[95:64]});
    expq.push_back({1'b0, tag_i[63:32]});
    expq.push_back({1'b1, tag_i[31:0]});
  endtask

  task automatic begin_xfer(input int ad, input int pt);
    nad = 0; npt = 0; nbeats = 0; ndone = 0; exp_ad_left = ad;
    beat_cyc.delete();
    start_i = 1'b1; ad_size_i = 7'(ad); pt_size_i = 7'(pt); src_left = 2 * (ad + pt);
    cyc_step();
    start_i = 1'b0;
  endtask

  task automatic pulse_tag();
    tag_valid_i = 1'b1;
    cyc_step();
    tag_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (ndone == 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    chk("done_seen", ndone != 0, 1'b1);
    cyc_step();
    cyc_step();
    chk("done_single", 64'(ndone), 64'd1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{2, 3, 1'b0, 64'hC0C0_0000_0000_0001, 64'hC0C0_0000_0000_0002, 2, 3, 10};
    vecs[1] = '{0, 0, 1'b0, 64'h0, 64'h0, 0, 0, 4};
    vecs[2] = '{0, 2, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 0, 2, 8};
    vecs[3] = '{1, 1, 1'b0, 64'h5555_6666_7777_8888, 64'h0, 1, 1, 6};
    vecs[4] = '{3, 0, 1'b1, 64'h0, 64'h0, 3, 0, 4};

    #1;
    chk("reset_outputs", {busy_o, done_o, s_ready_o, m_valid_o, m_last_o, ad_push_o, pt_push_o, ct_pop_o, m_data_o}, 64'h0);
    cyc_step();
    cyc_step();
    rst_n_i = 1'b1;
    cyc_step();
    chk("idle_after_reset", {busy_o, s_ready_o, m_valid_o, ct_pop_o}, 4'h0);

    for (int i = 0; i < 5; i++) begin
      tog = vecs[i].tog;
      load_expect(vecs[i].pt, vecs[i].ct0, vecs[i].ct1);
      begin_xfer(vecs[i].ad, vecs[i].pt);
      chk("busy_after_start", busy_o, 1'b1);
      pulse_tag();
      wait_done(2000);
      chk("ad_push_count", 64'(nad), 64'(vecs[i].n_ad));
      chk("pt_push_count", 64'(npt), 64'(vecs[i].n_pt));
      chk("m_beat_count", 64'(nbeats), 64'(vecs[i].n_beats));
      chk("expect_drained", 64'(expq.size()), 64'd0);
      if (i == 0) chk("first_ad_word", first_ad, 64'h00000001_00000002);
      tog = 1'b0;
      cyc_step();
    end

    // Full PT FIFO while the high half is held stalls the stream.
    pt_full_i = 1'b1;
    load_expect(1, 64'h0F0F_0F0F_F0F0_F0F0, 64'h0);
    begin_xfer(0, 1);
    for (int k = 0; k < 6; k++) cyc_step();
    @(negedge clk);
    chk("stall_ready_low", s_ready_o, 1'b0);
    chk("stall_no_push", 64'(npt), 64'd0);
    cyc_step();
    pt_full_i = 1'b0;
    for (int k = 0; k < 20 && npt == 0; k++) cyc_step();
    chk("push_after_full_drop", 64'(npt), 64'd1);
    pulse_tag();
    wait_done(2000);
    chk("stall_beats", 64'(nbeats), 64'd6);

    // Early tag plus an ignored second start: tag follows the last CT beat with no gap.
    load_expect(1, 64'h1234_5678_9ABC_DEF0, 64'h0);
    begin_xfer(0, 1);
    tag_valid_i = 1'b1;
    start_i = 1'b1; ad_size_i = 7'd3; pt_size_i = 7'd3;
    cyc_step();
    tag_valid_i = 1'b0;
    start_i = 1'b0;
    wait_done(2000);
    chk("early_tag_pt_push", 64'(npt), 64'd1);
    chk("early_tag_ad_push", 64'(nad), 64'd0);
    chk("early_tag_beats", 64'(nbeats), 64'd6);
    if (beat_cyc.size() >= 3) chk("tag_no_gap", 64'(beat_cyc[2] - beat_cyc[1]), 64'd1);
    else chk("tag_no_gap_beats", 64'(beat_cyc.size()), 64'd3);
`ifdef ASCON_IO_ERR_EN
    chk("err_sticky", err_o, 1'b1);
`endif

    // Reset with a held high half mid-PT, then a fresh transfer.
    begin_xfer(0, 2);
    src_left = 1;
    for (int k = 0; k < 20 && src_left != 0; k++) cyc_step();
    chk("half_sent", 64'(src_left), 64'd0);
    cyc_step();
    rst_n_i = 1'b0;
    #1;
    chk("async_reset_outputs", {busy_o, done_o, s_ready_o, m_valid_o, m_last_o, ad_push_o, pt_push_o, ct_pop_o, m_data_o}, 64'h0);
    chk("async_reset_data", ad_data_o | pt_data_o, 64'h0);
    half = 1'b0;
    expq.delete();
    ctq.delete();
    src_left = 0;
    cyc_step();
    rst_n_i = 1'b1;
    cyc_step();
    begin
      logic [31:0] d0;
      d0 = src_data;
      load_expect(0, 64'h0, 64'h0);
      begin_xfer(1, 0);
      pulse_tag();
      wait_done(2000);
      chk("fresh_ad_push", 64'(nad), 64'd1);
      chk("fresh_word", first_ad, {d0, d0 + 32'd1});
      chk("fresh_beats", 64'(nbeats), 64'd4);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
